mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one unified 32-bit instruction/data memory between the fetch stage (read-only) and the memory stage (read/write).
- Arbitrates between the two requesters and sequences a req/ack transaction on the memory port.
- Generates the fetch-side hold_pc/hold_if stalls and a memory-stage stall.
- A watchdog bounds each transaction; a starvation counter guarantees forward progress for fetch.

Parameters:
- MAX_STARVE, 4: consecutive data grants made while fetch waits before fetch is forced to win (1..15).
- TIMEOUT, 16: cycles mem_req may stay high without mem_ack before the transaction is aborted (2..255).
- ERR_DATA, 32'h00000000: read data returned on timeout (a MIPS NOP).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request, level, held until if_ack
- if_addr  in  32  fetch byte address (PC)
- if_rdata  out  32  instruction returned, valid when if_ack
- if_ack  out  1  one-cycle completion strobe to fetch
- dm_req  in  1  data request, level, held until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_rdata  out  32  load data, valid when dm_ack
- dm_ack  out  1  one-cycle completion strobe to memory stage
- mem_req  out  1  registered request to unified memory
- mem_we  out  1  registered write enable
- mem_addr  out  32  registered address
- mem_wdata  out  32  registered write data
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, any wait ≥0 cycles after mem_req
- hold_pc  out  1  = if_req & ~if_ack
- hold_if  out  1  = if_req & ~if_ack
- dm_stall  out  1  = dm_req & ~dm_ack
- bus_err  out  1  sticky, set on any timeout

Behaviour:
- States: IDLE, BUSY_IF, BUSY_DM.
- Reset: state IDLE; mem_req, mem_we, mem_addr, mem_wdata, starve_cnt, wd_cnt, bus_err all 0. Acks are therefore 0 and rdata outputs are 0.
- Reset mid-transaction: mem_req drops in the cycle after rst is sampled; no ack is issued; the in-flight memory op is abandoned.
- Request sampling: requests are sampled only in IDLE.
  - Grant is DM if dm_req & (~if_req | starve_cnt < MAX_STARVE); otherwise IF if if_req.
  - On grant, mem_req/we/addr/wdata are registered from the winner; the next state is BUSY_xx.
  - For an IF grant, mem_we is 0 and mem_wdata is 0.
- starve_cnt:
  - Increments on a DM grant while if_req is high.
  - Clears on an IF grant.
  - Saturates at MAX_STARVE.
- BUSY_xx while waiting: mem_req stays high and the address and data are stable. wd_cnt increments each cycle mem_req is high without mem_ack.
- BUSY_xx on mem_ack:
  - The owner's ack is driven combinationally in the same cycle, with rdata passthrough of mem_rdata (dm_rdata is don't-care for a write; drive mem_rdata).
  - mem_req drops next cycle, state returns to IDLE, wd_cnt clears.
- Timeout: when wd_cnt == TIMEOUT-1 and mem_ack is low, the owner's ack fires with rdata = ERR_DATA, bus_err is set, mem_req drops and the state returns to IDLE.
- Non-owner: ack and rdata stay 0.
- Minimum latency: request in IDLE cycle N, mem_req high in N+1, ack in N+1 with zero-wait memory. Each transaction occupies at least 2 cycles, including the IDLE cycle.
- Requester rule: a requester updates or deasserts its req on the edge ending its ack cycle. A req still high in IDLE is a new request.
- Simultaneous if_req & dm_req in IDLE: DM wins unless starved. With both requests held continuously, the pattern is MAX_STARVE DM grants then 1 IF grant.
- mem_ack in IDLE is ignored.
- bus_err clears only on rst.

Decomposition:
- Package mips_mem_pkg holds:
  - the state enum (IDLE, BUSY_IF, BUSY_DM);
  - the default ERR_DATA constant;
  - a request struct {we, addr, wdata}.
- No sub-module; the counters stay inline.

Test Plan:
- Fetch only, if_addr=0x40, zero-wait memory returning 0x8C220004:
  - mem_req is high 1 cycle after if_req, with mem_addr=0x40 and mem_we=0.
  - if_ack fires in that same cycle with if_rdata=0x8C220004.
  - hold_pc is 1 in the request cycle and 0 afterwards.
- Store, dm_we=1, addr=0x10, wdata=0xCAFEF00D, mem_ack after 3 wait cycles:
  - mem_req is high for 4 cycles with stable addr/data.
  - dm_ack fires in the 4th cycle; dm_stall is high until then.
- Both requests held continuously, MAX_STARVE=4, zero-wait memory: the grant order is DM,DM,DM,DM,IF repeating, and starve_cnt returns to 0 after each IF grant.
- mem_ack never asserted, TIMEOUT=16: after 16 cycles of mem_req the owner's ack fires with rdata=0x00000000, bus_err=1 and stays 1, and the next request proceeds normally.
- rst asserted during BUSY_DM: no dm_ack, and all outputs are 0 on the following cycle.
- mem_ack asserted while IDLE with no requests: no ack outputs and the state is unchanged.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the unified memory arbiter
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_IF,
      BUSY_DM
   } arb_state_t;

   // Returned on a watchdog abort; decodes as a MIPS NOP on the fetch side.
   localparam logic [31:0] DEFAULT_ERR_DATA = 32'h0000_0000;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_op_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one unified memory with watchdog and fetch anti-starvation
module mem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int unsigned MAX_STARVE = 4,
   parameter int unsigned TIMEOUT    = 16,
   parameter logic [31:0] ERR_DATA   = DEFAULT_ERR_DATA
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        hold_pc,
   output logic        hold_if,
   output logic        dm_stall,
   output logic        bus_err
);

   localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);
   localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);

   arb_state_t  state, state_next;
   mem_op_t     op, op_next;
   logic        req_q, req_next;
   logic [3:0]  starve_cnt, starve_next;
   logic [7:0]  wd_cnt, wd_next;
   logic        bus_err_q, bus_err_next;
   logic        done;
   logic [31:0] done_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         op         <= '0;
         req_q      <= 1'b0;
         starve_cnt <= '0;
         wd_cnt     <= '0;
         bus_err_q  <= 1'b0;
      end else begin
         state      <= state_next;
         op         <= op_next;
         req_q      <= req_next;
         starve_cnt <= starve_next;
         wd_cnt     <= wd_next;
         bus_err_q  <= bus_err_next;
      end
   end

   always_comb begin
      state_next   = state;
      op_next      = op;
      req_next     = req_q;
      starve_next  = starve_cnt;
      wd_next      = wd_cnt;
      bus_err_next = bus_err_q;
      done         = 1'b0;
      done_data    = '0;
      case (state)
         IDLE: begin
            // Data wins ties until fetch has lost MAX_STARVE grants in a row;
            // that same guard keeps the counter from exceeding its limit.
            if (dm_req && (!if_req || starve_cnt < STARVE_MAX)) begin
               state_next = BUSY_DM;
               req_next   = 1'b1;
               op_next    = '{we: dm_we, addr: dm_addr, wdata: dm_wdata};
               if (if_req) begin
                  starve_next = starve_cnt + 4'd1;
               end
            end else if (if_req) begin
               state_next  = BUSY_IF;
               req_next    = 1'b1;
               op_next     = '{we: 1'b0, addr: if_addr, wdata: 32'h0};
               starve_next = '0;
            end
         end
         BUSY_IF, BUSY_DM: begin
            if (mem_ack) begin
               done      = 1'b1;
               done_data = mem_rdata;
            end else if (wd_cnt == WD_LAST) begin
               done         = 1'b1;
               done_data    = ERR_DATA;
               bus_err_next = 1'b1;
            end else begin
               wd_next = wd_cnt + 8'd1;
            end
            if (done) begin
               state_next = IDLE;
               req_next   = 1'b0;
               wd_next    = '0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A reset arriving mid-transaction abandons it without acknowledging the owner.
   assign if_ack   = done & ~rst & (state == BUSY_IF);
   assign dm_ack   = done & ~rst & (state == BUSY_DM);
   assign if_rdata = if_ack ? done_data : 32'h0;
   assign dm_rdata = dm_ack ? done_data : 32'h0;

   assign mem_req   = req_q;
   assign mem_we    = op.we;
   assign mem_addr  = op.addr;
   assign mem_wdata = op.wdata;

   assign hold_pc  = if_req & ~if_ack;
   assign hold_if  = if_req & ~if_ack;
   assign dm_stall = dm_req & ~dm_ack;
   assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, dm_req, dm_we, mem_ack;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_ack, dm_ack, mem_req, mem_we, hold_pc, hold_if, dm_stall, bus_err;

   mem_arbiter #(.MAX_STARVE(4), .TIMEOUT(16), .ERR_DATA(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hold_pc(hold_pc), .hold_if(hold_if), .dm_stall(dm_stall), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_dm;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // memory model state
   int          wait_cfg = 0, wait_left = 0, txn_len = 0, last_len = 0;
   bit          in_txn = 0, mem_dead = 0, force_ack = 0;
   bit          if_keep = 0, dm_keep = 0;
   logic [31:0] start_addr, start_wdata;
   logic        seen_if_ack, seen_dm_ack, seen_hold_pc, seen_dm_stall;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input bit is_dm, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata);
      exp_t e;
      e.is_dm = is_dm; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (force_ack) begin
         mem_ack = 1'b1;
      end else if (mem_req) begin
         if (!in_txn) begin
            in_txn = 1; wait_left = wait_cfg; txn_len = 0;
            start_addr = mem_addr; start_wdata = mem_wdata;
            if (sb.size() > 0) begin
               check32("mem_addr", mem_addr, sb[0].addr);
               check32("mem_we", 32'(mem_we), 32'(sb[0].we));
               check32("mem_wdata", mem_wdata, sb[0].wdata);
            end
         end else begin
            check32("addr_stable", mem_addr, start_addr);
            check32("wdata_stable", mem_wdata, start_wdata);
         end
         txn_len++;
         if (!mem_dead && wait_left == 0) mem_ack = 1'b1;
         else begin
            mem_ack = 1'b0;
            if (wait_left > 0) wait_left--;
         end
      end else begin
         in_txn = 0; mem_ack = 1'b0;
      end
      #1;
      seen_if_ack = if_ack; seen_dm_ack = dm_ack;
      seen_hold_pc = hold_pc; seen_dm_stall = dm_stall;
      if (if_ack || dm_ack) begin
         check32("one_ack", 32'(if_ack & dm_ack), 32'd0);
         check32("ack_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check32("ack_port", 32'(dm_ack), 32'(e.is_dm));
            check32("rdata", dm_ack ? dm_rdata : if_rdata, e.rdata);
            check32("nonowner_rdata", dm_ack ? if_rdata : dm_rdata, 32'd0);
         end
         last_len = txn_len;
         if (if_ack && !if_keep) if_req = 1'b0;
         if (dm_ack && !dm_keep) dm_req = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      rst = 1'b1; if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
      if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 32'h8C22_0004;
      tick(); tick();
      rst = 1'b0;
      #1;
      check32("rst_mem_req", 32'(mem_req), 32'd0);
      check32("rst_mem_we", 32'(mem_we), 32'd0);
      check32("rst_mem_addr", mem_addr, 32'd0);
      check32("rst_mem_wdata", mem_wdata, 32'd0);
      check32("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
      check32("rst_rdata", if_rdata | dm_rdata, 32'd0);
      check32("rst_bus_err", 32'(bus_err), 32'd0);

      // fetch, zero-wait memory
      if_addr = 32'h40; if_req = 1'b1;
      push(0, 1'b0, 32'h40, 32'h0, 32'h8C22_0004);
      #1;
      check32("hold_pc_req", 32'(hold_pc), 32'd1);
      check32("hold_if_req", 32'(hold_if), 32'd1);
      tick();
      check32("fetch_ack", 32'(seen_if_ack), 32'd1);
      check32("fetch_len", 32'(last_len), 32'd1);
      tick();
      check32("hold_pc_after", 32'(hold_pc), 32'd0);

      // store with three wait cycles
      wait_cfg = 3;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hCAFE_F00D;
      push(1, 1'b1, 32'h10, 32'hCAFE_F00D, 32'h8C22_0004);
      for (int i = 0; i < 10; i++) begin
         tick();
         check32("dm_stall", 32'(seen_dm_stall), 32'(!seen_dm_ack));
         if (seen_dm_ack) break;
      end
      check32("store_drained", 32'(sb.size()), 32'd0);
      check32("store_len", 32'(last_len), 32'd4);

      // both held: DM x4 then IF, twice
      wait_cfg = 0; dm_we = 1'b0; dm_addr = 32'h200; dm_wdata = 32'h0; if_addr = 32'h100;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) push(1, 1'b0, 32'h200, 32'h0, 32'h8C22_0004);
         push(0, 1'b0, 32'h100, 32'h0, 32'h8C22_0004);
      end
      if_keep = 1; dm_keep = 1; if_req = 1'b1; dm_req = 1'b1;
      for (int i = 0; i < 40 && sb.size() > 0; i++) begin
         tick();
         if (seen_if_ack) check32("starve_clear", 32'(dut.starve_cnt), 32'd0);
         if (sb.size() == 0) begin
            if_req = 1'b0; dm_req = 1'b0; if_keep = 0; dm_keep = 0;
         end
      end
      check32("pattern_drained", 32'(sb.size()), 32'd0);
      tick();

      // watchdog abort, then a normal transaction
      mem_dead = 1; if_addr = 32'h80; if_req = 1'b1;
      push(0, 1'b0, 32'h80, 32'h0, 32'h0);
      for (int i = 0; i < 30; i++) begin
         tick();
         if (seen_if_ack) break;
      end
      check32("timeout_ack", 32'(seen_if_ack), 32'd1);
      check32("timeout_len", 32'(last_len), 32'd16);
      tick();
      check32("bus_err_set", 32'(bus_err), 32'd1);
      mem_dead = 0; mem_rdata = 32'h1234_5678;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20; dm_wdata = 32'h0;
      push(1, 1'b0, 32'h20, 32'h0, 32'h1234_5678);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (seen_dm_ack) break;
      end
      check32("post_timeout_drained", 32'(sb.size()), 32'd0);
      check32("post_timeout_len", 32'(last_len), 32'd1);
      check32("bus_err_sticky", 32'(bus_err), 32'd1);
      tick();

      // reset in BUSY_DM
      wait_cfg = 10;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h30; dm_wdata = 32'h1111_2222;
      tick(); tick();
      check32("busy_before_rst", 32'(mem_req), 32'd1);
      rst = 1'b1; dm_req = 1'b0;
      tick();
      check32("rst_no_ack", 32'(seen_dm_ack), 32'd0);
      check32("rst_busy_mem_req", 32'(mem_req), 32'd0);
      check32("rst_busy_mem", mem_addr | mem_wdata | 32'(mem_we), 32'd0);
      check32("rst_busy_flags", {28'd0, bus_err, dm_stall, hold_pc, dm_ack}, 32'd0);
      rst = 1'b0;
      tick();

      // mem_ack while idle
      force_ack = 1;
      tick(); tick();
      check32("idle_ack_ignored", {30'd0, seen_if_ack, seen_dm_ack}, 32'd0);
      check32("idle_state", 32'(dut.state), 32'(mips_mem_pkg::IDLE));
      check32("idle_mem_req", 32'(mem_req), 32'd0);
      force_ack = 0;
      tick();
      check32("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
